// File: rtl/pb_debouncer_pkg.sv
// Shared definitions for the push-button debouncer.
//   db_state_e      : debouncer FSM state (2 bits)
//   DefStableCycles : default qualification length (20 ms at 50 MHz)
//   DefCntW         : default stability counter width
package pb_debouncer_pkg;

   localparam int unsigned DefStableCycles = 1_000_000;
   localparam int unsigned DefCntW         = 20;

   typedef enum logic [1:0] {
      StLow  = 2'd0,
      StRise = 2'd1,
      StHigh = 2'd2,
      StFall = 2'd3
   } db_state_e;

endpackage

// File: rtl/pb_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both stages to 0
//   d_i   : asynchronous input level
//   q_o   : synchronized level, two clk_i edges behind d_i
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d_i;
      s2_d = s1_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronizes pb_raw and only changes pb_clean after the
// synchronized level has been stable for STABLE_CYCLES consecutive cycles.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   pb_raw   : raw bouncing button level (1 = pressed)
//   pb_clean : registered debounced level
//   busy     : registered, 1 while a candidate transition is being qualified
module pb_debouncer
   import pb_debouncer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DefStableCycles,
   parameter int unsigned CNT_W         = DefCntW
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_raw,
   output logic pb_clean,
   output logic busy
);

   if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("STABLE_CYCLES must be at least 1");
   end
   if (CNT_W < 1 || CNT_W < $clog2(STABLE_CYCLES)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for STABLE_CYCLES");
   end

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

   logic            pb_s2;
   db_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            pb_clean_q, pb_clean_d;
   logic            busy_q, busy_d;

   sync_2ff u_sync (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (pb_raw),
      .q_o   (pb_s2)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StLow: begin
            cnt_d = '0;
            if (pb_s2) begin
               state_d = StRise;
            end
         end
         StRise: begin
            if (!pb_s2) begin
               // Glitch rejected; pb_clean was never raised.
               state_d = StLow;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = StHigh;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StHigh: begin
            cnt_d = '0;
            if (!pb_s2) begin
               state_d = StFall;
            end
         end
         StFall: begin
            if (pb_s2) begin
               state_d = StHigh;
               cnt_d   = '0;
            end else if (cnt_q == CntMax) begin
               state_d = StLow;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StLow;
            cnt_d   = '0;
         end
      endcase

      // Outputs follow the next state so they are registered alongside it and
      // pb_clean can only move on entry to StLow/StHigh.
      pb_clean_d = (state_d == StHigh) || (state_d == StFall);
      busy_d     = (state_d == StRise) || (state_d == StFall);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StLow;
         cnt_q      <= '0;
         pb_clean_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pb_clean_q <= pb_clean_d;
         busy_q     <= busy_d;
      end
   end

   assign pb_clean = pb_clean_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_pb_debouncer.sv
// Bench for pb_debouncer with STABLE_CYCLES=4. A run-length reference model
// predicts pb_clean/busy per clock edge into a queue; a monitor pops and compares.
module tb_pb_debouncer;

   localparam int unsigned S = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pb_raw = 1'b0;
   logic pb_clean;
   logic busy;

   pb_debouncer #(
      .STABLE_CYCLES (S),
      .CNT_W         (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pb_raw   (pb_raw),
      .pb_clean (pb_clean),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic clean;
      logic busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_rise = 0;

   // Reference model: pb_clean flips once the level seen two edges late has
   // differed from it for S+1 consecutive edges; busy while such a run is open.
   bit   hist[$];
   bit   m_clean = 1'b0;
   int   m_run = 0;

   task automatic model_edge(input bit r, input bit rv);
      bit obs;
      exp_t e;
      if (rv) begin
         hist    = {1'b0, 1'b0};
         m_clean = 1'b0;
         m_run   = 0;
      end else begin
         obs = hist.pop_front();
         hist.push_back(r);
         if (obs != m_clean) begin
            m_run++;
            if (m_run == S + 1) begin
               m_clean = ~m_clean;
               m_run   = 0;
            end
         end else begin
            m_run = 0;
         end
      end
      e.clean = m_clean;
      e.busy  = (m_run != 0);
      exp_q.push_back(e);
   endtask

   task automatic step(input bit r, input bit rv);
      @(negedge clk);
      pb_raw = r;
      rst    = rv;
      @(posedge clk);
      model_edge(r, rv);
   endtask

   task automatic hold(input bit r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0);
   endtask

   // Monitor: one expected vector per clock edge.
   logic prev_clean = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (pb_clean !== e.clean || busy !== e.busy) begin
               n_bad++;
               $display("FAIL vec%0d t=%0t: pb_clean=%b busy=%b, expected pb_clean=%b busy=%b",
                        n_vec, $time, pb_clean, busy, e.clean, e.busy);
            end
            if (pb_clean === 1'b1 && prev_clean === 1'b0) n_rise++;
            prev_clean = pb_clean;
         end
      end
   end

   initial begin
      hist = {1'b0, 1'b0};

      // Reset, then idle low.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      hold(1'b0, 20);

      // Clean press and release.
      hold(1'b1, 12);
      hold(1'b0, 12);

      // Bouncing press: exactly one rising edge on pb_clean (one clk_en pulse).
      @(negedge clk);
      #1 n_rise = 0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      hold(1'b1, 12);
      @(negedge clk);
      #1;
      n_vec++;
      if (n_rise != 1) begin
         n_bad++;
         $display("FAIL one_pulse: %0d rising edges on pb_clean, expected 1", n_rise);
      end

      // Short low pulse while high is rejected.
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      hold(1'b1, 10);
      hold(1'b0, 12);

      // Reset while in RISE with cnt=2, button still held.
      hold(1'b1, 5);
      step(1'b1, 1'b1);
      hold(1'b1, 12);
      // Reset while in HIGH.
      step(1'b1, 1'b1);
      hold(1'b1, 10);
      hold(1'b0, 10);

      // Random bouncing segments with occasional resets.
      for (int seg = 0; seg < 400; seg++) begin
         bit lvl;
         int len;
         lvl = 1'($urandom_range(1, 0));
         len = (($urandom_range(3, 0)) == 0) ? int'($urandom_range(12, 6))
                                             : int'($urandom_range(5, 1));
         for (int i = 0; i < len; i++) begin
            step(lvl, ($urandom_range(199, 0) == 0));
         end
      end
      hold(1'b0, 10);

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected vectors left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pb_debouncer.md
PB_DEBOUNCER -- requirements
Module: pb_debouncer

Interface
REQ-001 SHALL expose parameter STABLE_CYCLES, default 1_000_000, consecutive stable sampled cycles required before the output changes (20 ms at 50 MHz).
REQ-002 SHALL expose parameter CNT_W, default 20, width of the stability counter; SHALL be at least ceil(log2(STABLE_CYCLES)).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pb_raw  input  1  asynchronous, bouncing push-button level (1 = pressed).
REQ-006 SHALL have port pb_clean  output  1  registered debounced level; drives the clkPB input of the downstream one-pulse stage.
REQ-007 SHALL have port busy  output  1  registered; 1 while a candidate transition is being qualified.

Function
REQ-008 SHALL pass pb_raw through a 2-flop synchronizer (s1, s2); only s2 is used by the FSM.
REQ-009 SHALL implement a 4-state FSM: LOW, RISE, HIGH, FALL.
REQ-010 LOW: pb_clean=0, busy=0; s2=1 -> RISE with cnt cleared to 0; else stay.
REQ-011 RISE: busy=1; s2=0 -> LOW, cnt cleared (glitch rejected, pb_clean never asserted); s2=1 and cnt=STABLE_CYCLES-1 -> HIGH and pb_clean set to 1; otherwise cnt increments.
REQ-012 HIGH: pb_clean=1, busy=0; s2=0 -> FALL with cnt cleared to 0; else stay.
REQ-013 FALL: busy=1; s2=1 -> HIGH, cnt cleared (pb_clean stays 1); s2=0 and cnt=STABLE_CYCLES-1 -> LOW and pb_clean cleared; otherwise cnt increments.
REQ-014 Latency: if pb_raw is first sampled 1 at edge k and stays 1, pb_clean SHALL be 1 after edge k+STABLE_CYCLES+2 and 0 before it; the falling direction is symmetric.
REQ-015 Any bounce shorter than STABLE_CYCLES sampled cycles SHALL produce no change on pb_clean.
REQ-016 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-017 pb_clean SHALL change only on LOW/HIGH entry, at most once per qualified transition (no double edges into the one-pulser).
REQ-018 Unreachable state encodings SHALL recover to LOW on the next edge.

Reset
REQ-019 On a clk edge with rst=1: state=LOW, cnt=0, s1=0, s2=0, pb_clean=0, busy=0.
REQ-020 Reset asserted mid-qualification (RISE/FALL) or in HIGH SHALL discard progress; after release, a held button SHALL requalify with the full REQ-014 latency.
REQ-021 rst SHALL take priority over every FSM transition in the same cycle.

Structure
REQ-022 The state typedef (LOW/RISE/HIGH/FALL, 2 bits) and the default STABLE_CYCLES constant SHALL live in the shared lab package.
REQ-023 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset to 0), reusable for other raw inputs.
REQ-024 Counter and FSM SHALL stay inside pb_debouncer; target 120-200 lines of RTL.

Verification (STABLE_CYCLES=4)
REQ-025 Reset then pb_raw held 0 for 20 cycles -> pb_clean=0, busy=0 throughout.
REQ-026 pb_raw 0->1 sampled at edge 10, held -> busy=1 from edge 12, pb_clean=1 after edge 16, busy=0 from edge 16.
REQ-027 Bounce 1,0,1,0 (one cycle each) then held 1 -> no pb_clean change during the bounce; pb_clean=1 exactly 6 edges after the last 0->1 sample.
REQ-028 pb_clean=1, pb_raw pulsed 0 for 2 cycles -> pb_clean stays 1, FSM returns to HIGH.
REQ-029 rst asserted for 1 cycle while in RISE with cnt=2, pb_raw held 1 -> pb_clean=0; rises 6 edges after the first post-reset sample of 1.
REQ-030 Chained with the one-pulse stage: one bouncing press -> exactly one single-cycle clk_en.
